// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [7:0] SYNC_BYTE      = 8'hA5;
  localparam int         BYTES_PER_WORD = 4;

endpackage

// File: rtl/idle_timer.sv
// Counts consecutive enabled cycles without a clear; expired once TIMEOUT is reached.
module idle_timer #(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear || !enable)           cnt_d = '0;
    else if (cnt_q != CW'(TIMEOUT)) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == CW'(TIMEOUT));

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader: assembles LE words into memory from address 0 and
// releases the core from reset only after a checksum-verified frame.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);

  state_e            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [15:0]       len_q, len_d;
  logic [ADDR_W:0]   widx_q, widx_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [31:0]       word_q, word_d;
  logic [7:0]        xor_q, xor_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic        accept, timed, expired;
  logic [31:0] n_ext;

  assign rx_ready = !rst && (state_q inside {S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHK});
  assign accept   = rx_valid && rx_ready;
  assign timed    = state_q inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CHK};
  assign n_ext    = {16'd0, rx_data, len_lo_q};

  idle_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .enable  (timed),
    .clear   (accept),
    .expired (expired)
  );

  always_comb begin
    state_d     = state_q;
    len_lo_d    = len_lo_q;
    len_d       = len_q;
    widx_d      = widx_q;
    bcnt_d      = bcnt_q;
    word_d      = word_q;
    xor_d       = xor_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    // Timeout wins over a byte arriving in the same cycle.
    if (timed && expired) begin
      state_d = S_ERR;
    end else if (accept) begin
      unique case (state_q)
        S_IDLE: if (rx_data == SYNC_BYTE) state_d = S_LEN_LO;
        S_LEN_LO: begin
          len_lo_d = rx_data;
          state_d  = S_LEN_HI;
        end
        S_LEN_HI: begin
          len_d = n_ext[15:0];
          if (n_ext > (32'd1 << ADDR_W)) state_d = S_ERR;
          else if (n_ext == 32'd0)       state_d = S_CHK;
          else                           state_d = S_DATA;
        end
        S_DATA: begin
          word_d[{bcnt_q, 3'b000} +: 8] = rx_data;
          xor_d  = xor_q ^ rx_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'(BYTES_PER_WORD - 1)) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = widx_q[ADDR_W-1:0];
            mem_wdata_d = {rx_data, word_q[23:0]};
            widx_d      = widx_q + (ADDR_W+1)'(1);
            if (32'(widx_q) + 32'd1 == {16'd0, len_q}) state_d = S_CHK;
          end
        end
        S_CHK: state_d = (rx_data == xor_q) ? S_DONE : S_ERR;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_lo_q    <= '0;
      len_q       <= '0;
      widx_q      <= '0;
      bcnt_q      <= '0;
      word_q      <= '0;
      xor_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      len_lo_q    <= len_lo_d;
      len_q       <= len_d;
      widx_q      <= widx_d;
      bcnt_q      <= bcnt_d;
      word_q      <= word_d;
      xor_q       <= xor_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_ERR);
  assign cpu_rst   = (state_q != S_DONE);

endmodule
